// File: rtl/param_div_pkg.sv
// Shared arithmetic typedefs for the divider block.
package param_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } div_state_t;

endpackage

// File: rtl/param_div_if.sv
// Request/result bundle between a divider client and param_div.
interface param_div_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;

    modport master (
        output start, a, b,
        input  busy, done, q, r, dbz
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, dbz
    );
endinterface

// File: rtl/param_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module param_div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   rem,
    input  logic             nbit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_nx,
    output logic             qbit
);
    logic [WIDTH+1:0] wide;
    logic [WIDTH:0]   diff;

    assign wide   = {rem, nbit};
    assign qbit   = (wide >= {2'b00, dvs});
    assign diff   = wide[WIDTH:0] - {1'b0, dvs};
    assign rem_nx = qbit ? diff : wide[WIDTH:0];
endmodule

// File: rtl/param_div.sv
// Signed iterative divider: restoring division on magnitudes, one bit per clock.
module param_div
    import param_div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    param_div_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] amag;
    logic [WIDTH-1:0] bmag;
    logic             sq;
    logic             sr;
    logic             zero;
    logic             qbit;

    // Magnitudes fit unsigned WIDTH bits, including the most-negative value.
    assign amag = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign bmag = bus.b[WIDTH-1] ? -bus.b : bus.b;

    param_div_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .nbit   (dvd[WIDTH-1]),
        .dvs    (dvs),
        .rem_nx (rem_nx),
        .qbit   (qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            sq       <= 1'b0;
            sr       <= 1'b0;
            zero     <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.q    <= '0;
            bus.r    <= '0;
            bus.dbz  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= DIVIDE;
                        cnt      <= CW'(WIDTH);
                        rem      <= '0;
                        dvd      <= amag;
                        dvs      <= bmag;
                        sr       <= bus.a[WIDTH-1];
                        sq       <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        zero     <= (bus.b == '0);
                        bus.busy <= 1'b1;
                    end
                end
                DIVIDE: begin
                    // dvd shifts dividend bits out and quotient bits in.
                    rem <= rem_nx;
                    dvd <= {dvd[WIDTH-2:0], qbit};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (zero) begin
                        bus.q <= '1;
                    end else begin
                        bus.q <= sq ? -dvd : dvd;
                    end
                    bus.r    <= sr ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    bus.dbz  <= zero;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_div.sv
// Self-checking bench for param_div at WIDTH=8 and WIDTH=16.
module tb_param_div;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   k0     = 0;
    int   lat;

    param_div_if #(.WIDTH(8))  i8 ();
    param_div_if #(.WIDTH(16)) i16 ();

    param_div #(.WIDTH(8)) d8 (
        .clk   (clk),
        .reset (reset),
        .bus   (i8.slave)
    );

    param_div #(.WIDTH(16)) d16 (
        .clk   (clk),
        .reset (reset),
        .bus   (i16.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gq(input int w);
        return (w == 8) ? 32'(i8.q) : 32'(i16.q);
    endfunction

    function automatic logic [31:0] gr(input int w);
        return (w == 8) ? 32'(i8.r) : 32'(i16.r);
    endfunction

    function automatic logic [31:0] gz(input int w);
        return (w == 8) ? 32'(i8.dbz) : 32'(i16.dbz);
    endfunction

    function automatic logic [31:0] gb(input int w);
        return (w == 8) ? 32'(i8.busy) : 32'(i16.busy);
    endfunction

    function automatic logic dn(input int w);
        return (w == 8) ? i8.done : i16.done;
    endfunction

    function automatic longint sx(input logic [31:0] v, input int w);
        longint m;
        longint x;
        m = (longint'(1) << w) - 1;
        x = longint'(v) & m;
        if (x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
        return x;
    endfunction

    task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (w == 8) begin
            i8.a = a[7:0];
            i8.b = b[7:0];
            i8.start = 1'b1;
        end else begin
            i16.a = a[15:0];
            i16.b = b[15:0];
            i16.start = 1'b1;
        end
        @(posedge clk);
        #1;
        k0 = cyc;
        i8.start = 1'b0;
        i16.start = 1'b0;
    endtask

    task automatic await(input int w, output int l);
        bit got;
        got = 1'b0;
        l = -1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(posedge clk);
            #1;
            if (dn(w)) begin
                got = 1'b1;
                l = cyc - k0;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL timeout w=%0d: no done within 40 cycles", w);
        end
    endtask

    task automatic check(input int w, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        longint sa, sb, mask, eq, er, qs, rs;
        logic ed;
        mask = (longint'(1) << w) - 1;
        sa = sx(a, w);
        sb = sx(b, w);
        if (sb == 0) begin
            eq = mask;
            er = sa & mask;
            ed = 1'b1;
        end else begin
            eq = (sa / sb) & mask;
            er = (sa % sb) & mask;
            ed = 1'b0;
        end
        chk({tag, "_q"}, gq(w), 32'(eq));
        chk({tag, "_r"}, gr(w), 32'(er));
        chk({tag, "_dbz"}, gz(w), 32'(ed));
        if (sb != 0) begin
            qs = sx(gq(w), w);
            rs = sx(gr(w), w);
            chk({tag, "_ident"}, 32'((qs * sb + rs) & mask), 32'(sa & mask));
            chk({tag, "_rmag"}, 32'(((rs < 0) ? -rs : rs) < ((sb < 0) ? -sb : sb)), 32'(1));
            chk({tag, "_rsign"}, 32'(rs == 0 || ((rs < 0) == (sa < 0))), 32'(1));
        end
    endtask

    task automatic run(input int w, input logic [31:0] a, input logic [31:0] b,
                       input string tag, output int l);
        issue(w, a, b);
        await(w, l);
        if (l >= 0) begin
            chk({tag, "_lat"}, 32'(l), 32'(w + 1));
            chk({tag, "_busy"}, gb(w), 32'(0));
            check(w, a, b, tag);
        end
    endtask

    initial begin
        bit seen;
        logic [31:0] ra, rb;
        i8.start = 1'b0;
        i8.a = '0;
        i8.b = '0;
        i16.start = 1'b0;
        i16.a = '0;
        i16.b = '0;
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", gb(8), 32'(0));
        chk("rst_done", 32'(i8.done), 32'(0));
        chk("rst_q", gq(8), 32'(0));
        chk("rst_r", gr(8), 32'(0));
        chk("rst_dbz", gz(8), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        run(8, 100, 7, "p100_7", lat);
        chk("p100_7_qc", gq(8), 32'h0E);
        chk("p100_7_rc", gr(8), 32'h02);
        chk("p100_7_lat9", 32'(lat), 32'(9));
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q", gq(8), 32'h0E);

        run(8, -100, 7, "n100_7", lat);
        chk("n100_7_qc", gq(8), 32'hF2);
        chk("n100_7_rc", gr(8), 32'hFE);
        run(8, 100, -7, "p100_n7", lat);
        chk("p100_n7_qc", gq(8), 32'hF2);
        chk("p100_n7_rc", gr(8), 32'h02);
        run(8, -128, -1, "min_n1", lat);
        chk("min_n1_qc", gq(8), 32'h80);
        chk("min_n1_rc", gr(8), 32'h00);
        chk("min_n1_dc", gz(8), 32'h0);
        run(8, -128, 1, "min_1", lat);
        chk("min_1_qc", gq(8), 32'h80);
        chk("min_1_rc", gr(8), 32'h00);
        run(8, 5, 0, "dz", lat);
        chk("dz_qc", gq(8), 32'hFF);
        chk("dz_rc", gr(8), 32'h05);
        chk("dz_dc", gz(8), 32'h1);
        run(8, 6, 3, "b2b", lat);
        chk("b2b_qc", gq(8), 32'h02);
        chk("b2b_rc", gr(8), 32'h00);
        chk("b2b_dc", gz(8), 32'h0);

        // start with new operands while busy must be ignored
        issue(8, 100, 7);
        repeat (2) @(posedge clk);
        #1;
        i8.start = 1'b1;
        i8.a = 8'd1;
        i8.b = 8'd1;
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        chk("ign_busy", gb(8), 32'(1));
        await(8, lat);
        chk("ign_lat", 32'(lat), 32'(9));
        chk("ign_q", gq(8), 32'h0E);
        chk("ign_r", gr(8), 32'h02);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_idle", gb(8), 32'(0));

        // reset in the middle of a division
        issue(8, 100, 7);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mrst_busy", gb(8), 32'(0));
        chk("mrst_q", gq(8), 32'(0));
        chk("mrst_r", gr(8), 32'(0));
        chk("mrst_dbz", gz(8), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (i8.done) seen = 1'b1;
        end
        chk("mrst_nodone", 32'(seen), 32'(0));
        run(8, 9, 2, "after_rst", lat);
        chk("after_rst_qc", gq(8), 32'h04);
        chk("after_rst_rc", gr(8), 32'h01);

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 20 == 0) rb = 0;
            if (i % 20 == 7) rb = 32'hFFFF_FFFF;
            run(8, ra, rb, "rnd8", lat);
        end

        run(16, 32'hFFFF_8000, 32'hFFFF_FFFF, "min16", lat);
        chk("min16_qc", gq(16), 32'h8000);
        run(16, 32'd1000, 32'd0, "dz16", lat);
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 1) rb = rb & 32'h0000_00FF;
            if (i % 20 == 0) rb = 0;
            run(16, ra, rb, "rnd16", lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
